aes_sbox_lanes: RTL and testbench
=================================

// Module: aes_sbox_lanes
// PURPOSE
//  Pipelined, multi-lane AES S-box unit with valid/ready handshake at both ends.
//  Substitutes LANES bytes per transfer, forward or (optionally) inverse S-box.
//  Shared by the SubBytes datapath (LANES=16) and key expansion SubWord (LANES=4).
//  Replaces ad-hoc use of single-byte combinational S-box lookups.
// PARAMETERS
//  LANES      4   bytes substituted per transfer; 1..16; data width = 8*LANES
//  OUT_REG    1   1: registered output stage (latency 2); 0: output from stage 1 (latency 1)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous reset, active-low
//  flush      in   1        synchronous clear of all in-flight words
//  in_valid   in   1        input word valid
//  in_ready   out  1        unit accepts input this cycle
//  in_mode    in   1        0 = forward S-box, 1 = inverse S-box (see CONFIGURATION)
//  in_data    in   8*LANES  lane i = in_data[8i+7:8i]
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_data   out  8*LANES  lane i = S(in lane i) or InvS(in lane i)
//  busy       out  1        any stage holds a valid word
// BEHAVIOUR
//  - Reset (reset_n=0, async): all stage valid bits=0, out_data=0, out_valid=0, busy=0;
//    in_ready=1 once reset_n deasserts.
//  - Stage 1 (S1): captures in_data/in_mode on in_valid&in_ready. Lookup is combinational
//    on S1 contents; all lanes use the same mode; lanes are independent.
//  - OUT_REG=1: stage 2 (S2) captures lookup result when S1 valid and S2 empty or draining.
//    out_valid=S2 valid, out_data=S2 data. Latency 2 cycles accept->out_valid, no stall.
//  - OUT_REG=0: out_valid=S1 valid, out_data=lookup(S1). Latency 1 cycle.
//  - Handshake: transfer on valid&ready. out_data/out_valid held stable while
//    out_valid=1 & out_ready=0. in_valid may not depend on in_ready.
//  - in_ready = !S1.v | (S1 advances this cycle); S1 advances when next stage empty or
//    draining (OUT_REG=1) or out_ready (OUT_REG=0). No combinational in_valid->in_ready path.
//  - Full throughput: one word per cycle with out_ready held high.
//  - Full: both stages valid and out_ready=0 -> in_ready=0, no word lost or duplicated.
//  - Simultaneous accept and drain on same cycle: both occur; ordering preserved (FIFO).
//  - flush=1: all valid bits cleared next edge; input presented that cycle is dropped;
//    in_ready=0 during flush; out_data keeps last value (don't care when out_valid=0).
//  - Reset mid-transfer: in-flight words discarded, outputs to reset values immediately.
//  - busy = OR of stage valid bits.
// CONFIGURATION
//  AES_SBOX_INV_EN defined: inverse S-box table compiled in; in_mode selects per word.
//  AES_SBOX_INV_EN undefined: forward table only; in_mode ignored (forward always);
//    port remains for pin compatibility.
// TESTING
//  1. LANES=4, forward, in_data=32'h00010253 -> out_data=32'h637c77ed, out_valid 2 cycles later.
//  2. LANES=1, sweep 8'h00..8'hff back-to-back, out_ready=1 -> 256 results, 1/cycle,
//     e.g. 00->63, 53->ed, ff->16; match FIPS-197 table in order.
//  3. AES_SBOX_INV_EN, in_mode=1, in_data=32'h16ed7c63 -> 32'hff530100; mixed-mode
//     alternating words map correctly per word.
//  4. Backpressure: out_ready=0 for 5 cycles after 3 inputs -> in_ready=0 after 2 accepted,
//     out_data stable; release -> words out in order, none lost/duplicated.
//  5. flush with both stages valid -> next cycle out_valid=0, busy=0, in_ready=1.
//  6. reset_n pulsed low mid-stream -> out_valid=0, out_data=0 asynchronously; clean restart.

Source files
------------

// File: rtl/aes_sbox_lanes.sv
// Pipelined multi-lane AES S-box with valid/ready handshake on both sides.
// Define AES_SBOX_INV_EN to compile in the inverse S-box (selected per word by in_mode).
module aes_sbox_lanes #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned DW = 8 * LANES;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = a[i] ^ a[3'(i + 4)] ^ a[3'(i + 5)] ^ a[3'(i + 6)] ^ a[3'(i + 7)];
    end
    return b ^ 8'h63;
  endfunction

`ifdef AES_SBOX_INV_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = a[3'(i + 2)] ^ a[3'(i + 5)] ^ a[3'(i + 7)];
    end
    return b ^ 8'h05;
  endfunction
`endif

  logic          s1_v_q, s1_v_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [DW-1:0] lut_c;
  logic          s1_adv_c;
  logic          accept_c;

`ifdef AES_SBOX_INV_EN
  logic s1_mode_q, s1_mode_d;

  always_comb begin
    lut_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lut_c[8*l +: 8] = s1_mode_q ? gf_inv(inv_affine(s1_data_q[8*l +: 8]))
                                  : fwd_affine(gf_inv(s1_data_q[8*l +: 8]));
    end
  end
`else
  // Forward-only build: mode pin kept for pin compatibility
  logic unused_mode;
  assign unused_mode = in_mode;

  always_comb begin
    lut_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lut_c[8*l +: 8] = fwd_affine(gf_inv(s1_data_q[8*l +: 8]));
    end
  end
`endif

  assign in_ready = ~flush & (~s1_v_q | s1_adv_c);
  assign accept_c = in_valid & in_ready;

  // Stage 1 next state: flush wins, then capture, then drain
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
`ifdef AES_SBOX_INV_EN
    s1_mode_d = s1_mode_q;
`endif
    if (flush) begin
      s1_v_d = 1'b0;
    end else if (accept_c) begin
      s1_v_d    = 1'b1;
      s1_data_d = in_data;
`ifdef AES_SBOX_INV_EN
      s1_mode_d = in_mode;
`endif
    end else if (s1_adv_c) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
`ifdef AES_SBOX_INV_EN
      s1_mode_q <= 1'b0;
`endif
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
`ifdef AES_SBOX_INV_EN
      s1_mode_q <= s1_mode_d;
`endif
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          s2_v_q, s2_v_d;
      logic [DW-1:0] s2_data_q, s2_data_d;

      assign s1_adv_c = s1_v_q & (~s2_v_q | out_ready);

      always_comb begin
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        if (flush) begin
          s2_v_d = 1'b0;
        end else if (s1_adv_c) begin
          s2_v_d    = 1'b1;
          s2_data_d = lut_c;
        end else if (out_ready) begin
          s2_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_v_q    <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_v_q    <= s2_v_d;
          s2_data_q <= s2_data_d;
        end
      end

      assign out_valid = s2_v_q;
      assign out_data  = s2_data_q;
      assign busy      = s1_v_q | s2_v_q;
    end else begin : g_noreg
      // Output taken straight from the stage-1 lookup; zeroed when idle
      assign s1_adv_c  = s1_v_q & out_ready;
      assign out_valid = s1_v_q;
      assign out_data  = s1_v_q ? lut_c : '0;
      assign busy      = s1_v_q;
    end
  endgenerate

endmodule

// File: tb/tb_aes_sbox_lanes.sv
// Scoreboard bench for aes_sbox_lanes (LANES=4, OUT_REG=1) against a log/exp-table S-box model.
module tb_aes_sbox_lanes;
  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8 * LANES;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;

  aes_sbox_lanes #(.LANES(LANES), .OUT_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [7:0]    sbox_t [256];
  logic [7:0]    isbox_t[256];
  logic [DW-1:0] exp_q[$];
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int k);
    return 8'((a << k) | (a >> (8 - k)));
  endfunction

  // Model: inverses from exp/log tables over generator 3, then the affine map as rotations
  task automatic build_tables();
    logic [7:0] ex[256];
    int         lg[256];
    logic [7:0] v;
    logic [7:0] inv;
    logic [7:0] s;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = v;
      lg[v] = i;
      v = v ^ ({v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00));
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[a]  = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] d, input logic m);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < int'(LANES); l++) begin
`ifdef AES_SBOX_INV_EN
      r[8*l +: 8] = m ? isbox_t[d[8*l +: 8]] : sbox_t[d[8*l +: 8]];
`else
      r[8*l +: 8] = m ? sbox_t[d[8*l +: 8]] : sbox_t[d[8*l +: 8]];
`endif
    end
    return r;
  endfunction

  // Monitor: handshakes are stable at the falling edge and take effect on the next rise
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_q) begin
        chk("hold_valid", DW'(out_valid), DW'(1));
        chk("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h, expected no output", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      hold_q    = out_valid && !out_ready && !flush;
      hold_data = out_data;
      if (in_valid && in_ready) exp_q.push_back(ref_word(in_data, in_mode));
      if (flush) exp_q.delete();
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic m);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
  endtask

  // Single word through an idle pipe: result must appear exactly two edges after acceptance
  task automatic one_word(input string name, input logic [DW-1:0] d, input logic m,
                          input logic [DW-1:0] req);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1_valid"}, DW'(out_valid), DW'(0));
    @(negedge clk);
    chk({name, "_lat2_valid"}, DW'(out_valid), DW'(1));
    chk({name, "_data"}, out_data, req);
    step();
  endtask

  initial begin
    int stall;
    int gaps;
    int n0;
    int w;
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", DW'(busy), DW'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    step();

    one_word("fwd", 32'h00010253, 1'b0, 32'h637c77ed);
`ifdef AES_SBOX_INV_EN
    one_word("inv", 32'h16ed7c63, 1'b1, 32'hff530100);
`else
    one_word("mode_ignored", 32'h16ed7c63, 1'b1, 32'h475510fb);
`endif
    for (int i = 0; i < 8; i++) send($urandom, 1'(i));
    repeat (3) step();

    // Full-rate sweep of all byte values, one word per cycle
    out_ready = 1'b1;
    stall = 0;
    gaps  = 0;
    n0    = n_out;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      in_mode  = 1'b0;
      @(negedge clk);
      if (!in_ready) stall++;
      if (i >= 2 && !out_valid) gaps++;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("sweep_stalls", DW'(stall), DW'(0));
    chk("sweep_gaps", DW'(gaps), DW'(0));
    chk("sweep_count", DW'(n_out - n0), DW'(256));

    // Backpressure: two words fill the pipe, the third must wait
    out_ready = 1'b0;
    send(32'h01020304, 1'b0);
    send(32'hA0B1C2D3, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h5566EEFF;
    in_mode  = 1'b0;
    stall = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) stall++;
    end
    chk("bp_in_ready_low", DW'(stall), DW'(0));
    chk("bp_busy", DW'(busy), DW'(1));
    step();
    out_ready = 1'b1;
    send(32'h5566EEFF, 1'b0);
    repeat (4) step();
    chk("bp_drained", DW'(exp_q.size()), DW'(0));

    // Flush with both stages occupied; the word offered alongside flush is dropped
    out_ready = 1'b0;
    send(32'h11223344, 1'b0);
    send(32'h99887766, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", DW'(out_valid), DW'(0));
    chk("flush_busy", DW'(busy), DW'(0));
    chk("flush_in_ready", DW'(in_ready), DW'(1));
    chk("flush_queue", DW'(exp_q.size()), DW'(0));
    step();

    // Random traffic with occasional flushes and a mid-stream reset
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", DW'(out_valid), DW'(0));
        chk("midrst_out_data", out_data, '0);
        chk("midrst_busy", DW'(busy), DW'(0));
        exp_q.delete();
        hold_q   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
      end
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      in_mode   = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 64) == 0;
      step();
    end

    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 20) begin
      step();
      w++;
    end
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));
    chk("final_busy", DW'(busy), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
